// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: shared types and sizing for the triple-buffer frame scheduler.
package frame_buf_pkg;
  localparam int MAX_BUF = 4;
  localparam int BUF_IDX_W = $clog2(MAX_BUF);
  typedef enum logic [1:0] {FREE, WRITING, READY, READING} buf_state_e;
  typedef enum logic [1:0] {W_IDLE, W_START, W_ACTIVE} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_GRANT, R_HOLD} rd_state_e;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/frame_buf_pick.sv
// frame_buf_pick: lowest-index FREE buffer, else the READY buffer (dropping its frame).
module frame_buf_pick
  import frame_buf_pkg::*;
(
  input  logic [MAX_BUF-1:0]   free_vec,
  input  logic [MAX_BUF-1:0]   ready_vec,
  output logic [BUF_IDX_W-1:0] idx,
  output logic                 found,
  output logic                 drop
);
  always_comb begin
    idx = '0;
    for (int i = MAX_BUF - 1; i >= 0; i--) if (ready_vec[i]) idx = BUF_IDX_W'(i);
    for (int i = MAX_BUF - 1; i >= 0; i--) if (free_vec[i]) idx = BUF_IDX_W'(i);
    found = (|free_vec) | (|ready_vec);
    drop = ~(|free_vec) & (|ready_vec);
  end
endmodule

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: assigns DDR frame buffers to the writer and grants the newest
// complete frame to the reader, tracking per-buffer ownership.
module frame_buf_sched
  import frame_buf_pkg::*;
#(
  parameter int          NUM_BUF    = 3,
  parameter logic [31:0] BUF_BASE   = 32'h0000_0000,
  parameter logic [31:0] BUF_STRIDE = 32'h0008_0000
) (
  input  logic        clk_100,
  input  logic        reset_n,
  input  logic        vsync_in,
  output logic        wr_start_frame,
  output logic [31:0] wr_addr_buf,
  input  logic        wr_end_frame,
  input  logic        rd_frame_req,
  output logic        rd_grant,
  output logic [31:0] rd_addr_buf,
  input  logic        rd_frame_done,
  output logic [15:0] frame_drop_cnt,
  output logic [15:0] vsync_ovr_cnt,
  output logic        wr_busy,
  output logic        rd_busy
);
  localparam logic [31:0] ADDR_TAB [MAX_BUF] = '{
    BUF_BASE,
    BUF_BASE + BUF_STRIDE,
    BUF_BASE + 32'd2 * BUF_STRIDE,
    BUF_BASE + 32'd3 * BUF_STRIDE
  };
  buf_state_e buf_st [MAX_BUF];
  buf_state_e buf_nxt [MAX_BUF];
  logic [MAX_BUF-1:0] free_vec, ready_vec;
  logic [BUF_IDX_W-1:0] pick_idx, ready_idx, wr_idx, rd_idx;
  logic pick_found, pick_drop, wr_pick, wr_done, rd_claim, rd_rel;
  wr_state_e wr_state, wr_nxt;
  rd_state_e rd_state, rd_nxt;
  // slots at or above NUM_BUF are masked out so they are never picked or granted
  for (genvar i = 0; i < MAX_BUF; i++) begin : g_vec
    assign free_vec[i]  = (i < NUM_BUF) && (buf_st[i] == FREE);
    assign ready_vec[i] = (i < NUM_BUF) && (buf_st[i] == READY);
  end
  always_comb begin
    ready_idx = '0;
    for (int i = MAX_BUF - 1; i >= 0; i--) if (ready_vec[i]) ready_idx = BUF_IDX_W'(i);
  end
  frame_buf_pick u_pick (
    .free_vec  (free_vec),
    .ready_vec (ready_vec),
    .idx       (pick_idx),
    .found     (pick_found),
    .drop      (pick_drop)
  );
  assign wr_pick  = (wr_state == W_IDLE) && vsync_in && pick_found;
  assign wr_done  = (wr_state == W_ACTIVE) && wr_end_frame;
  assign rd_claim = (rd_state == R_IDLE) && rd_frame_req && (|ready_vec);
  assign rd_rel   = (rd_state == R_HOLD) && rd_frame_done;
  assign wr_busy  = wr_state != W_IDLE;
  assign rd_busy  = rd_state != R_IDLE;
  always_comb begin
    wr_nxt = wr_state;
    unique case (wr_state)
      W_IDLE:   if (wr_pick) wr_nxt = W_START;
      W_START:  wr_nxt = W_ACTIVE;
      W_ACTIVE: if (wr_done) wr_nxt = W_IDLE;
      default:  wr_nxt = W_IDLE;
    endcase
  end
  always_comb begin
    rd_nxt = rd_state;
    unique case (rd_state)
      R_IDLE:  if (rd_claim) rd_nxt = R_GRANT;
      R_GRANT: rd_nxt = R_HOLD;
      R_HOLD:  if (rd_rel) rd_nxt = R_IDLE;
      default: rd_nxt = R_IDLE;
    endcase
  end
  // A reader claim in the same cycle as a frame end takes the old READY frame,
  // so it must not be released to FREE by the writer.
  always_comb begin
    buf_nxt = buf_st;
    if (wr_done && !rd_claim) for (int i = 0; i < MAX_BUF; i++) if (buf_st[i] == READY) buf_nxt[i] = FREE;
    if (rd_claim) buf_nxt[ready_idx] = READING;
    if (wr_done) buf_nxt[wr_idx] = READY;
    if (wr_pick) buf_nxt[pick_idx] = WRITING;
    if (rd_rel) buf_nxt[rd_idx] = FREE;
  end
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_nxt;
      rd_state <= rd_nxt;
    end
  end
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_BUF; i++) buf_st[i] <= FREE;
      wr_idx         <= '0;
      rd_idx         <= '0;
      wr_addr_buf    <= BUF_BASE;
      rd_addr_buf    <= BUF_BASE;
      wr_start_frame <= 1'b0;
      rd_grant       <= 1'b0;
      frame_drop_cnt <= '0;
      vsync_ovr_cnt  <= '0;
    end else begin
      buf_st         <= buf_nxt;
      wr_start_frame <= wr_state == W_START;
      rd_grant       <= rd_state == R_GRANT;
      if (wr_pick) begin
        wr_idx      <= pick_idx;
        wr_addr_buf <= ADDR_TAB[pick_idx];
      end
      if (rd_claim) begin
        rd_idx      <= ready_idx;
        rd_addr_buf <= ADDR_TAB[ready_idx];
      end
      if (wr_pick && pick_drop) frame_drop_cnt <= sat_inc(frame_drop_cnt);
      if (vsync_in && wr_state != W_IDLE) vsync_ovr_cnt <= sat_inc(vsync_ovr_cnt);
    end
  end
endmodule
